// File: rtl/serializer.sv
// serializer: parallel-to-serial transmitter for the 16-bit serial link.
// Accepts words on a valid/ready handshake and shifts them out MSB-first,
// one bit per clock. A one-word holding buffer lets consecutive words
// stream without an idle cycle between them.
//
// Handshake: a word transfers on a rising edge where data_val_i && data_rdy_o.
// data_rdy_o depends only on the holding-buffer flag, so it never has a
// combinational path from data_val_i. A sender must keep data_i/data_mod_i
// stable and data_val_i high until the transfer edge.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sh;
    logic [MOD_W:0]    cnt;
    logic [DATA_W-1:0] pend_data;
    logic [MOD_W-1:0]  pend_mod;
    logic              pend_full;
    logic              take;
    logic              last_bit;

    // A mod value of 0 stands for a full-width word.
    function automatic logic [MOD_W:0] len_of(input logic [MOD_W-1:0] m);
        if (m == '0) begin
            return (MOD_W+1)'(DATA_W);
        end
        return {1'b0, m};
    endfunction

    assign take     = data_val_i && data_rdy_o;
    assign last_bit = (cnt == (MOD_W+1)'(1));

    // Control FSM, shift register, bit counter and holding buffer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            pend_data <= '0;
            pend_mod  <= '0;
            pend_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sh    <= data_i;
                        cnt   <= len_of(data_mod_i);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // Next word: buffered word first, then a same-cycle
                        // transfer, otherwise the stream ends.
                        if (pend_full) begin
                            sh        <= pend_data;
                            cnt       <= len_of(pend_mod);
                            pend_full <= 1'b0;
                        end else if (take) begin
                            sh  <= data_i;
                            cnt <= len_of(data_mod_i);
                        end else begin
                            sh    <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        sh  <= sh << 1;
                        cnt <= cnt - 1'b1;
                        if (take) begin
                            pend_data <= data_i;
                            pend_mod  <= data_mod_i;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of flops; serial data is forced low when idle.
    assign data_rdy_o     = !pend_full;
    assign ser_data_val_o = (state == SHIFT);
    assign ser_data_o     = (state == SHIFT) && sh[DATA_W-1];
    assign busy_o         = (state == SHIFT) || pend_full;

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter, the sending end of the team's 16-bit serial link. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, with a bit-valid strobe. The output framing is exactly what the link's deserializer expects: `data_mod_i = 0` gives 16 consecutive valid bits, and `ser_data_o` is the first bit of each word. A one-word holding buffer lets consecutive words stream with no idle cycle between them.

## Interface
- `DATA_W`, default 16: parallel word width.
- `MOD_W`, default `$clog2(DATA_W)` = 4: width of the bit-count field.
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `rst_n_i`, input, 1: reset, asynchronous, active-low.
- `data_i`, input, `DATA_W`: word to send. `data_i[DATA_W-1]` is sent first.
- `data_mod_i`, input, `MOD_W`: number of bits to send. 0 means the full `DATA_W`; 1..15 means that many MSBs.
- `data_val_i`, input, 1: `data_i` and `data_mod_i` are valid.
- `data_rdy_o`, output, 1: block can accept a word. A transfer happens when `data_val_i && data_rdy_o`.
- `ser_data_o`, output, 1: serial bit.
- `ser_data_val_o`, output, 1: `ser_data_o` is valid this cycle.
- `busy_o`, output, 1: shifting is in progress or the holding buffer is full.

## Operation
- **State:**
  - FSM with states IDLE and SHIFT.
  - Shift register `sh[DATA_W-1:0]`.
  - Remaining-bit counter `cnt`, `MOD_W+1` bits wide, so it can hold 16.
  - Holding buffer: word, mod value and `pend_full` flag.
- **Length decode:** `len = (mod == 0) ? DATA_W : mod`. The top `len` bits of the word are sent and the rest are discarded.
- **IDLE:**
  - On a transfer, load `sh <= data_i`, `cnt <= len`, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT, each cycle:**
  - Drive `ser_data_o = sh[DATA_W-1]` and `ser_data_val_o = 1`.
  - Update `sh <= sh << 1` and `cnt <= cnt - 1`.
- **Accepting while shifting:** a transfer in SHIFT, when it is not the last-bit cycle, writes the holding buffer and sets `pend_full`.
- **Last-bit cycle (`cnt == 1`):** the next word is chosen in this priority order:
  1. Holding buffer: load `sh`/`cnt` from it, clear `pend_full`, stay in SHIFT.
  2. A transfer on this same cycle: load `sh`/`cnt` directly from `data_i`, bypassing the buffer, and stay in SHIFT.
  3. Neither: go to IDLE.
- **Ready:** `data_rdy_o = !pend_full`, combinational from state. A word is never dropped. `data_val_i` while `data_rdy_o = 0` is held off, not lost.
- **Link compatibility:** the deserializer only frames 16-bit words, so senders on that link must use mod 0. Other mod values are legal for this block; their framing downstream is the sender's responsibility.
- **Reset (`rst_n_i` low), asynchronous:**
  - State goes to IDLE; `cnt`, `sh` and `pend_full` go to 0; the buffer is cleared.
  - `ser_data_o = 0`, `ser_data_val_o = 0`, `busy_o = 0`, `data_rdy_o = 1`.
  - Inputs are ignored while in reset.
- **Reset mid-word:** the current word and any pending word are abandoned. `ser_data_val_o` drops in the same cycle reset asserts; no partial continuation follows release.
- **Outputs when not valid:** `ser_data_o = 0` whenever `ser_data_val_o = 0`.

## Timing
- **Latency:** a transfer in cycle T in IDLE gives its first bit at cycle T+1. Bit k (k = 0..len-1) appears at T+1+k, on consecutive cycles with no gaps.
- **Outputs are registered:** `ser_data_o`, `ser_data_val_o` and `busy_o` come from flops or state. `data_rdy_o` is a decode of `pend_full` only and has no combinational path from `data_val_i`.
- **Back-to-back streaming:** when the next word is buffered or arrives on the last-bit cycle, its first bit follows the previous last bit in the very next cycle. `ser_data_val_o` stays high continuously.
- **Throughput:** sustained 1 bit per cycle. At most two words are in flight (shifting plus buffered).
- **`busy_o`:** goes high in the cycle after the first accept and goes low in the cycle after the last bit of the last word.

## Test plan
- **Single full word:** reset, then `data_i = 16'hA5C3`, `mod = 0` for one cycle. Expect `ser_data_val_o` high for exactly 16 cycles starting next cycle, bits `1010_0101_1100_0011`, then IDLE with `busy_o = 0`.
- **Partial word:** `data_i = 16'hF000`, `mod = 3`. Expect 3 valid bits `1,1,1`, then `ser_data_val_o = 0`.
- **Back-to-back:** hold `data_val_i` high with words `16'h0001` then `16'h8000`, both mod 0. Expect 32 contiguous valid cycles: bit 16 = 1, bit 17 = 1, all other bits 0. `data_rdy_o` drops to 0 after the second accept until the buffer drains.
- **Last-cycle bypass:** present a second word (`16'hFFFF`) only on the cycle where the first word's bit 16 is out. Expect no gap and 16 ones following.
- **Reset mid-word:** assert `rst_n_i` low after 5 bits of `16'hFFFF`. Expect `ser_data_val_o = 0` immediately, `data_rdy_o = 1`, and no bits after release until a new transfer.
- **Loopback:** connect to the deserializer and send 100 random mod-0 words. Every `deser_data_o` must match the sent word, in order.
